// File: rtl/violation_reset_ctrl_pkg.sv
// Shared definitions for the violation reset controller.
//   state_e            : controller FSM state encodings
//   Cause*             : bit positions inside viol_cause
//   TcbBaseDefault/... : default trusted-code-region bounds
//   in_tcb()           : inclusive unsigned 16-bit range check of a pc against the TCB
package violation_reset_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHold    = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam int unsigned CauseWidth   = 4;
  localparam int unsigned CausePmem    = 0;
  localparam int unsigned CauseIntrCfg = 1;
  localparam int unsigned CauseIrqTcb  = 2;
  localparam int unsigned CauseAtomic  = 3;

  localparam logic [15:0] TcbBaseDefault = 16'hA002;
  localparam logic [15:0] TcbSizeDefault = 16'h4000;

  localparam int unsigned HoldCntWidth = 8;

  // Upper bound is formed in 17 bits so a region touching 16'hFFFF cannot wrap.
  function automatic logic in_tcb(input logic [15:0] pc, input logic [15:0] base,
                                  input logic [15:0] size);
    logic [16:0] top;
    top = {1'b0, base} + {1'b0, size};
    return (pc >= base) && ({1'b0, pc} <= top);
  endfunction

endpackage

// File: rtl/violation_reset_ctrl_if.sv
// Bundle between the security monitor (master) and the violation reset controller (slave).
//   viol_pmem/intr_cfg/irq_tcb/atomic : violation levels from the individual monitors
//   pc, data_addr                      : CPU state captured at the start of an episode
//   clr                                : request to clear the captured record
//   cpu_reset                          : stretched CPU reset
//   viol_cause/pc/addr/count, clr_denied : violation record
interface violation_reset_ctrl_if;
  import violation_reset_ctrl_pkg::*;

  logic                  viol_pmem;
  logic                  viol_intr_cfg;
  logic                  viol_irq_tcb;
  logic                  viol_atomic;
  logic [15:0]           pc;
  logic [15:0]           data_addr;
  logic                  clr;
  logic                  cpu_reset;
  logic [CauseWidth-1:0] viol_cause;
  logic [15:0]           viol_pc;
  logic [15:0]           viol_addr;
  logic [7:0]            viol_count;
  logic                  clr_denied;

  modport master (
    output viol_pmem, viol_intr_cfg, viol_irq_tcb, viol_atomic, pc, data_addr, clr,
    input  cpu_reset, viol_cause, viol_pc, viol_addr, viol_count, clr_denied
  );

  modport slave (
    input  viol_pmem, viol_intr_cfg, viol_irq_tcb, viol_atomic, pc, data_addr, clr,
    output cpu_reset, viol_cause, viol_pc, viol_addr, viol_count, clr_denied
  );

endinterface

// File: rtl/violation_reset_ctrl_rst_stretch_counter.sv
// Down-counter that times the CPU reset hold window.
//   i_clk, i_reset_n : clock and synchronous active-low reset
//   i_load, i_load_val : load the counter (takes priority over decrement)
//   i_dec            : decrement by one; holds at zero
//   o_zero           : counter currently reads zero
module rst_stretch_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [Width-1:0] i_load_val,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/violation_reset_ctrl.sv
// Violation reset controller: on any monitor violation, captures a violation record and holds
// the CPU in reset for HOLD_CYCLES cycles, extending the hold while violations persist.
//   i_clk, i_reset_n : clock and synchronous active-low reset
//   io_bus (slave)   : violation inputs, pc/data_addr, clr request, cpu_reset and the record
module violation_reset_ctrl
  import violation_reset_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [15:0] TCB_BASE    = TcbBaseDefault,
  parameter logic [15:0] TCB_SIZE    = TcbSizeDefault
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  violation_reset_ctrl_if.slave io_bus
);

  localparam logic [HoldCntWidth-1:0] HoldLoad = HoldCntWidth'(HOLD_CYCLES - 1);

  state_e                r_state, w_state_next;
  logic                  r_cpu_reset;
  logic [CauseWidth-1:0] r_cause, w_cause_next;
  logic [15:0]           r_vpc, w_vpc_next;
  logic [15:0]           r_vaddr, w_vaddr_next;
  logic [7:0]            r_count, w_count_next;
  logic                  r_denied, w_denied_next;

  logic [CauseWidth-1:0] w_viol_vec;
  logic                  w_any_viol;
  logic                  w_in_tcb;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;
  logic                  w_cnt_zero;

  always_comb begin
    w_viol_vec               = '0;
    w_viol_vec[CausePmem]    = io_bus.viol_pmem;
    w_viol_vec[CauseIntrCfg] = io_bus.viol_intr_cfg;
    w_viol_vec[CauseIrqTcb]  = io_bus.viol_irq_tcb;
    w_viol_vec[CauseAtomic]  = io_bus.viol_atomic;
  end

  assign w_any_viol = |w_viol_vec;
  assign w_in_tcb   = in_tcb(io_bus.pc, TCB_BASE, TCB_SIZE);

  always_comb begin
    w_state_next  = r_state;
    w_cause_next  = r_cause;
    w_vpc_next    = r_vpc;
    w_vaddr_next  = r_vaddr;
    w_count_next  = r_count;
    w_cnt_load    = 1'b0;
    w_cnt_dec     = 1'b0;
    // An untrusted clear attempt is flagged whatever the state.
    w_denied_next = r_denied | (io_bus.clr & ~w_in_tcb);

    unique case (r_state)
      StIdle, StRelease: begin
        if (w_any_viol) begin
          w_state_next = StHold;
          w_cause_next = r_cause | w_viol_vec;
          w_vpc_next   = io_bus.pc;
          w_vaddr_next = io_bus.data_addr;
          w_count_next = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
          w_cnt_load   = 1'b1;
        end else begin
          w_state_next = StIdle;
          // Trusted clear only from a quiet IDLE; a coincident violation has already won above.
          if ((r_state == StIdle) && io_bus.clr && w_in_tcb) begin
            w_cause_next  = '0;
            w_vpc_next    = '0;
            w_vaddr_next  = '0;
            w_denied_next = 1'b0;
          end
        end
      end
      StHold: begin
        w_cause_next = r_cause | w_viol_vec;
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (w_any_viol) begin
          w_cnt_load = 1'b1;
        end else begin
          w_state_next = StRelease;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_cpu_reset <= 1'b0;
      r_cause     <= '0;
      r_vpc       <= '0;
      r_vaddr     <= '0;
      r_count     <= '0;
      r_denied    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cpu_reset <= (w_state_next == StHold);
      r_cause     <= w_cause_next;
      r_vpc       <= w_vpc_next;
      r_vaddr     <= w_vaddr_next;
      r_count     <= w_count_next;
      r_denied    <= w_denied_next;
    end
  end

  rst_stretch_counter #(
    .Width (HoldCntWidth)
  ) u_rst_stretch_counter (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (HoldLoad),
    .o_zero     (w_cnt_zero)
  );

  assign io_bus.cpu_reset  = r_cpu_reset;
  assign io_bus.viol_cause = r_cause;
  assign io_bus.viol_pc    = r_vpc;
  assign io_bus.viol_addr  = r_vaddr;
  assign io_bus.viol_count = r_count;
  assign io_bus.clr_denied = r_denied;

endmodule

// File: tb/tb_violation_reset_ctrl.sv
// Scoreboard bench for violation_reset_ctrl: each driven cycle pushes the reference model's
// expected outputs; a monitor pops and compares them after the following clock edge.
module tb_violation_reset_ctrl;

  localparam int TbHold = 16;
  localparam int TbBase = 'hA002;
  localparam int TbSize = 'h4000;

  typedef struct packed {
    logic        rst;
    logic [3:0]  cause;
    logic [15:0] vpc;
    logic [15:0] vaddr;
    logic [7:0]  cnt;
    logic        den;
  } exp_t;

  logic clk;
  logic reset_n;
  violation_reset_ctrl_if u_if ();

  violation_reset_ctrl #(
    .HOLD_CYCLES (TbHold),
    .TCB_BASE    (16'hA002),
    .TCB_SIZE    (16'h4000)
  ) u_dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .io_bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: episode described by remaining reset cycles and a one-cycle release flag.
  int          m_left;
  bit          m_rel;
  logic [3:0]  m_cause;
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  int          m_cnt;
  bit          m_den;

  task automatic model(input bit rn, input logic [3:0] v, input logic [15:0] p,
                       input logic [15:0] a, input bit c);
    bit   any;
    bit   tcb;
    bit   was_rel;
    exp_t e;
    any = (v != 4'b0);
    tcb = (int'(p) >= TbBase) && (int'(p) <= TbBase + TbSize);
    if (!rn) begin
      m_left = 0; m_rel = 0; m_cause = '0; m_pc = '0; m_addr = '0; m_cnt = 0; m_den = 0;
    end else begin
      if (c && !tcb) m_den = 1;
      if (m_left > 0) begin
        m_cause = m_cause | v;
        m_left--;
        if (m_left == 0) begin
          if (any) m_left = TbHold;
          else     m_rel = 1;
        end
      end else begin
        was_rel = m_rel;
        m_rel   = 0;
        if (any) begin
          m_cause = m_cause | v;
          m_pc    = p;
          m_addr  = a;
          if (m_cnt < 255) m_cnt++;
          m_left  = TbHold;
        end else if (c && tcb && !was_rel) begin
          m_cause = '0; m_pc = '0; m_addr = '0; m_den = 0;
        end
      end
    end
    e.rst   = (m_left > 0);
    e.cause = m_cause;
    e.vpc   = m_pc;
    e.vaddr = m_addr;
    e.cnt   = 8'(m_cnt);
    e.den   = m_den;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rn, input logic [3:0] v, input logic [15:0] p,
                      input logic [15:0] a, input bit c);
    @(negedge clk);
    reset_n              = rn;
    u_if.viol_pmem       = v[0];
    u_if.viol_intr_cfg   = v[1];
    u_if.viol_irq_tcb    = v[2];
    u_if.viol_atomic     = v[3];
    u_if.pc              = p;
    u_if.data_addr       = a;
    u_if.clr             = c;
    model(rn, v, p, a, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0, 16'h1234, 16'h5678, 1'b0);
  endtask

  // Monitor: every edge that follows a driven cycle presents one output sample.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e         = exp_q.pop_front();
        got.rst   = u_if.cpu_reset;
        got.cause = u_if.viol_cause;
        got.vpc   = u_if.viol_pc;
        got.vaddr = u_if.viol_addr;
        got.cnt   = u_if.viol_count;
        got.den   = u_if.clr_denied;
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs cyc%0d: got rst=%b cause=%b pc=%h addr=%h cnt=%0d den=%b, want rst=%b cause=%b pc=%h addr=%h cnt=%0d den=%b",
                   cyc, got.rst, got.cause, got.vpc, got.vaddr, got.cnt, got.den,
                   e.rst, e.cause, e.vpc, e.vaddr, e.cnt, e.den);
        end
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rv;
    logic [15:0] rp;
    reset_n = 1'b0;
    u_if.viol_pmem = 0; u_if.viol_intr_cfg = 0; u_if.viol_irq_tcb = 0; u_if.viol_atomic = 0;
    u_if.pc = '0; u_if.data_addr = '0; u_if.clr = 0;

    step(1'b0, 4'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 4'b0, 16'h0, 16'h0, 1'b0);
    idle(3);

    // Single pmem pulse: 16-cycle hold and full capture.
    step(1'b1, 4'b0001, 16'hE010, 16'hE020, 1'b0);
    idle(20);

    // Trusted and untrusted clears, including both range bounds and just outside them.
    step(1'b1, 4'b0, 16'hA100, 16'h0, 1'b1); idle(2);
    step(1'b1, 4'b0001, 16'hE010, 16'hE020, 1'b0); idle(20);
    step(1'b1, 4'b0, 16'h4000, 16'h0, 1'b1); idle(2);
    step(1'b1, 4'b0, 16'hA001, 16'h0, 1'b1); idle(1);
    step(1'b1, 4'b0, 16'hA002, 16'h0, 1'b1); idle(1);
    step(1'b1, 4'b0, 16'hE003, 16'h0, 1'b1); idle(1);
    step(1'b1, 4'b0, 16'hE002, 16'h0, 1'b1); idle(1);

    // intr_cfg joins at HOLD cycle 5; trusted clr mid-hold is ignored.
    step(1'b1, 4'b0001, 16'hE010, 16'hE020, 1'b0);
    idle(4);
    step(1'b1, 4'b0010, 16'hBEEF, 16'hCAFE, 1'b0);
    step(1'b1, 4'b0, 16'hA100, 16'h0, 1'b1);
    idle(20);
    step(1'b1, 4'b0, 16'hA100, 16'h0, 1'b1); idle(1);

    // irq_tcb held 20 cycles: one reload.
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0100, 16'h3000, 16'h3004, 1'b0);
    idle(40);

    // Violation with coincident trusted clr: violation wins.
    step(1'b1, 4'b1000, 16'hA100, 16'h0042, 1'b1);
    idle(16);
    step(1'b1, 4'b0001, 16'h0100, 16'h0200, 1'b0);  // re-trigger from RELEASE
    idle(20);

    // Saturation over 256 episodes, then reset during HOLD.
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 4'b0001, 16'(k), 16'(k + 1), 1'b0);
      idle(TbHold + 2);
    end
    step(1'b1, 4'b0100, 16'h1111, 16'h2222, 1'b0);
    idle(5);
    step(1'b0, 4'b0, 16'h0, 16'h0, 1'b0);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      rp = ($urandom_range(0, 1) == 0) ? 16'(TbBase + $urandom_range(0, TbSize))
                                        : 16'($urandom_range(0, 65535));
      step(($urandom_range(0, 199) != 0), rv, rp, 16'($urandom_range(0, 65535)),
           ($urandom_range(0, 7) == 0));
    end
    idle(2);

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/violation_reset_ctrl.md
VIOLATION_RESET_CTRL -- requirements
Module: violation_reset_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, sets the number of cycles cpu_reset stays asserted per violation episode; legal range is 2..255.
REQ-002 Parameter TCB_BASE, default 16'hA002, is the base of the trusted code region.
REQ-003 Parameter TCB_SIZE, default 16'h4000, is the trusted region span; a pc is in TCB when TCB_BASE <= pc <= TCB_BASE+TCB_SIZE.
REQ-004 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 viol_pmem  input  1  violation level from the program-memory write monitor.
REQ-007 viol_intr_cfg  input  1  violation level from the interrupt-config write monitor.
REQ-008 viol_irq_tcb  input  1  violation level from the TCB interrupt/DMA monitor.
REQ-009 viol_atomic  input  1  violation level from the TCB atomicity monitor.
REQ-010 pc  input  16  current program counter.
REQ-011 data_addr  input  16  current data-bus address.
REQ-012 clr  input  1  single-cycle request to clear the captured violation record.
REQ-013 cpu_reset  output  1  active-high reset to the CPU, registered.
REQ-014 viol_cause  output  4  sticky cause bits {atomic, irq_tcb, intr_cfg, pmem}, with pmem as bit 0.
REQ-015 viol_pc  output  16  pc captured at the first violation of an episode.
REQ-016 viol_addr  output  16  data_addr captured at the first violation of an episode.
REQ-017 viol_count  output  8  saturating count of violation episodes.
REQ-018 clr_denied  output  1  sticky flag set by a clr request issued from outside the TCB.

Function
REQ-019 The FSM SHALL have states IDLE, HOLD and RELEASE.
REQ-020 Define any_viol as the OR of the four viol_* inputs.
REQ-021 In IDLE with any_viol=1, the next edge SHALL:
- OR the active inputs into viol_cause;
- load viol_pc and viol_addr;
- increment viol_count, saturating at 255;
- load the hold counter with HOLD_CYCLES-1;
- enter HOLD.
REQ-022 cpu_reset SHALL be 1 exactly when the state is HOLD, giving a latency of one cycle from violation to reset.
REQ-023 In HOLD, the hold counter SHALL decrement every cycle.
REQ-024 In HOLD, active viol_* bits SHALL be ORed into viol_cause, while viol_pc, viol_addr and viol_count stay unchanged.
REQ-025 In HOLD with the counter at 0:
- if any_viol=1, the counter SHALL reload to HOLD_CYCLES-1 and the state stays HOLD;
- otherwise the state SHALL move to RELEASE.
REQ-026 RELEASE SHALL last exactly one cycle, with cpu_reset=0.
REQ-027 From RELEASE, any_viol=1 SHALL start a new episode (capture and count as in REQ-021) and enter HOLD; otherwise the state SHALL move to IDLE.
REQ-028 clr SHALL take effect only in IDLE, with pc in TCB and any_viol=0; its effect is to zero viol_cause, viol_pc, viol_addr and clr_denied on the next edge.
REQ-029 viol_count SHALL NOT be cleared by clr; only reset_n clears it.
REQ-030 clr with pc outside TCB, in any state, SHALL set clr_denied and leave all other state unchanged.
REQ-031 clr in HOLD or RELEASE with pc in TCB SHALL be ignored.
REQ-032 If a violation and a clr arrive in the same IDLE cycle, the violation SHALL win and the clr SHALL be dropped.
REQ-033 The TCB range compare SHALL be unsigned 16-bit with inclusive bounds.

Reset
REQ-034 With reset_n=0 at a clock edge, the block SHALL enter IDLE and set cpu_reset=0, viol_cause=0, viol_pc=0, viol_addr=0, viol_count=0, clr_denied=0 and the hold counter to 0.
REQ-035 reset_n asserted during HOLD SHALL abort the episode, deasserting cpu_reset at the same edge.
REQ-036 The CPU reset that this block drives SHALL NOT feed back into reset_n.

Structure
REQ-037 The shared defines package SHALL hold the state encodings (IDLE=2'd0, HOLD=2'd1, RELEASE=2'd2), the cause-bit indices and the default TCB_BASE/TCB_SIZE values.
REQ-038 The hold counter with its load/decrement/zero logic SHALL be a sub-module named rst_stretch_counter, 8 bits wide.
REQ-039 The top-level monitor SHALL instantiate this block and drive the viol_* inputs from its individual monitor resets.

Verification
REQ-040 viol_pmem=1 for 1 cycle in IDLE at pc=16'hE010, data_addr=16'hE020 -> cpu_reset high for 16 cycles starting the next cycle, viol_cause=4'b0001, viol_pc=16'hE010, viol_addr=16'hE020, viol_count=1.
REQ-041 viol_irq_tcb held 20 cycles -> cpu_reset high for 32 cycles (one reload), viol_count=1, viol_cause=4'b0100.
REQ-042 viol_intr_cfg pulse at HOLD cycle 5 of a pmem episode -> viol_cause=4'b0011, viol_pc unchanged, viol_count unchanged.
REQ-043 In IDLE, clr at pc=16'hA100 -> record zeroed, viol_count kept; clr at pc=16'h4000 -> clr_denied=1, record kept.
REQ-044 Violation and clr at pc=16'hA100 in the same IDLE cycle -> episode starts and the record is not cleared.
REQ-045 256 separate episodes -> viol_count=255; then reset_n=0 during HOLD -> all outputs 0 on the next edge.
